// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWrite,
        StDone
    } state_e;

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned lines);
        return addr_w - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_align.sv
// Store lane/byte-enable generation and load byte/half extraction with extension.
module dcache_align
    import dcache_pkg::*;
(
    input  logic [2:0]  width_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] line_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = line_data_i[{offset_i, 3'b000} +: 8];
    assign half_sel = offset_i[1] ? line_data_i[31:16] : line_data_i[15:0];

    always_comb begin
        st_be_o    = 4'hF;
        st_wdata_o = wdata_i;
        case (width_i[1:0])
            2'b00: begin
                st_be_o    = 4'b0001 << offset_i;
                st_wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = 4'b0011 << {offset_i[1], 1'b0};
                st_wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data_o = line_data_i;
        case (width_i)
            W_B:     ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            W_BU:    ld_data_o = {24'h0, byte_sel};
            W_H:     ld_data_o = {{16{half_sel[15]}}, half_sel};
            W_HU:    ld_data_o = {16'h0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
module dcache
    import dcache_pkg::*;
#(
    parameter int unsigned LINES  = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic              we,
    input  logic [2:0]        width,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned IDX_W = idx_width(LINES);
    localparam int unsigned TAG_W = tag_width(ADDR_W, LINES);

    state_e           state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       offset;
    logic [31:0]      cur_line;
    logic             hit;

    logic             line_we;
    logic [31:0]      line_data_d;
    logic [TAG_W-1:0] line_tag_d;

    logic [31:0]      st_wdata;
    logic [3:0]       st_be;
    logic [31:0]      ld_data;
    logic [31:0]      merged;

    assign offset   = addr[1:0];
    assign idx      = addr[2 +: IDX_W];
    assign tag      = addr[ADDR_W-1 -: TAG_W];
    assign cur_line = data_q[idx];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    dcache_align u_align (
        .width_i     (width),
        .offset_i    (offset),
        .wdata_i     (wdata),
        .line_data_i (cur_line),
        .st_wdata_o  (st_wdata),
        .st_be_o     (st_be),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        merged = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (st_be[b]) begin
                merged[8*b +: 8] = st_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        line_we     = 1'b0;
        line_data_d = cur_line;
        line_tag_d  = tag;
        stall       = 1'b0;
        rdata       = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;

        case (state_q)
            StIdle: begin
                // A store takes priority over a simultaneous load.
                if (we) begin
                    state_d = StWrite;
                    stall   = 1'b1;
                end else if (re) begin
                    if (hit) begin
                        rdata = ld_data;
                    end else begin
                        state_d = StFill;
                        stall   = 1'b1;
                    end
                end
            end
            StFill: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {addr[ADDR_W-1:2], 2'b00};
                mem_be   = 4'hF;
                if (mem_ack) begin
                    line_we      = 1'b1;
                    line_data_d  = mem_rdata;
                    valid_d[idx] = 1'b1;
                    state_d      = StDone;
                end
            end
            StWrite: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr[ADDR_W-1:2], 2'b00};
                mem_be    = st_be;
                mem_wdata = st_wdata;
                if (mem_ack) begin
                    // No-write-allocate: only an already-resident line is updated.
                    if (hit) begin
                        line_we     = 1'b1;
                        line_data_d = merged;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (re && !we) begin
                    rdata = ld_data;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= line_data_d;
            tag_q[idx]  <= line_tag_d;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Directed scoreboard bench for dcache with a behavioural word memory.
module tb_dcache;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic [2:0]  width;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mem_model [logic [29:0]];

    dcache #(
        .LINES  (64),
        .ADDR_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .re        (re),
        .we        (we),
        .width     (width),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Called at a falling edge; drives one access and plays memory until it completes.
    task automatic do_access(input string nm, input logic is_ld, input logic [2:0] wd,
                             input logic [31:0] a, input logic [31:0] d, input int waits,
                             input int exp_stall, input logic exp_req,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int          cycles;
        int          wait_cnt;
        logic        saw_req;
        logic [29:0] wa;
        logic [31:0] word;
        cycles   = 0;
        wait_cnt = 0;
        saw_req  = 1'b0;
        wa       = a[31:2];
        addr     = a;
        wdata    = d;
        width    = wd;
        re       = is_ld;
        we       = !is_ld;
        while (1) begin
            #1;
            if (!stall) break;
            cycles++;
            if (cycles > 60) begin
                check({nm, "_timeout"}, 32'(cycles), 32'(exp_stall));
                break;
            end
            if (mem_req) begin
                check({nm, "_maddr"}, mem_addr, {a[31:2], 2'b00});
                check({nm, "_mbe"}, {28'h0, mem_be}, {28'h0, exp_be});
                check({nm, "_mwe"}, {31'h0, mem_we}, {31'h0, !is_ld});
                if (!is_ld) check({nm, "_mwdata"}, mem_wdata, exp_wd);
                saw_req = 1'b1;
                if (wait_cnt == waits) begin
                    mem_ack = 1'b1;
                    if (is_ld) begin
                        mem_rdata = mem_model.exists(wa) ? mem_model[wa] : 32'h0;
                    end else begin
                        word = mem_model.exists(wa) ? mem_model[wa] : 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (exp_be[b]) word[8*b +: 8] = exp_wd[8*b +: 8];
                        end
                        mem_model[wa] = word;
                    end
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
        check({nm, "_stalls"}, 32'(cycles), 32'(exp_stall));
        check({nm, "_req"}, {31'h0, saw_req}, {31'h0, exp_req});
        if (is_ld) begin
            if (exp_q.size() == 0) begin
                check({nm, "_sb_empty"}, 32'h1, 32'h0);
            end else begin
                check({nm, "_rdata"}, rdata, exp_q.pop_front());
            end
        end
        @(negedge clk);
        re = 1'b0;
        we = 1'b0;
    endtask

    task automatic load(input string nm, input logic [2:0] wd, input logic [31:0] a,
                        input int waits, input int exp_stall, input logic exp_req,
                        input logic [31:0] exp_rd);
        exp_q.push_back(exp_rd);
        do_access(nm, 1'b1, wd, a, 32'h0, waits, exp_stall, exp_req, 4'hF, 32'h0);
    endtask

    task automatic store(input string nm, input logic [2:0] wd, input logic [31:0] a,
                         input logic [31:0] d, input int waits,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
        do_access(nm, 1'b0, wd, a, d, waits, waits + 2, 1'b1, exp_be, exp_wd);
    endtask

    initial begin
        rst       = 1'b1;
        addr      = 32'h0;
        wdata     = 32'h0;
        re        = 1'b0;
        we        = 1'b0;
        width     = W_W;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        mem_model[30'h40] = 32'hDEADBEEF;
        mem_model[30'hC1] = 32'hCAFEF00D;

        #12;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Stray ack while idle must be ignored.
        #1 mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("idle_ack_req", {31'h0, mem_req}, 32'h0);
        check("idle_ack_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);

        load("cold_lw", W_W, 32'h100, 2, 4, 1'b1, 32'hDEADBEEF);
        load("hit_lw", W_W, 32'h100, 0, 0, 1'b0, 32'hDEADBEEF);

        store("sw_hit", W_W, 32'h100, 32'h80FF7F01, 1, 4'hF, 32'h80FF7F01);
        load("lw_after_sw", W_W, 32'h100, 0, 0, 1'b0, 32'h80FF7F01);
        load("lb_101", W_B, 32'h101, 0, 0, 1'b0, 32'h0000007F);
        load("lb_103", W_B, 32'h103, 0, 0, 1'b0, 32'hFFFFFF80);
        load("lbu_103", W_BU, 32'h103, 0, 0, 1'b0, 32'h00000080);
        load("lhu_102", W_HU, 32'h102, 0, 0, 1'b0, 32'h000080FF);
        load("lh_102", W_H, 32'h102, 0, 0, 1'b0, 32'hFFFF80FF);

        store("sb_102", W_B, 32'h102, 32'h000000AA, 0, 4'b0100, 32'hAAAAAAAA);
        load("lw_after_sb", W_W, 32'h100, 0, 0, 1'b0, 32'h80AA7F01);
        store("sh_100", W_H, 32'h100, 32'h0000BEEF, 0, 4'b0011, 32'hBEEFBEEF);
        load("lw_after_sh", W_W, 32'h100, 0, 0, 1'b0, 32'h80AABEEF);

        store("sw_miss", W_W, 32'h200, 32'h12345678, 0, 4'hF, 32'h12345678);
        load("lw_noalloc", W_W, 32'h200, 1, 3, 1'b1, 32'h12345678);

        load("conflict_a", W_W, 32'h100, 0, 2, 1'b1, 32'h80AABEEF);
        load("conflict_b", W_W, 32'h200, 0, 2, 1'b1, 32'h12345678);
        load("conflict_c", W_W, 32'h100, 0, 2, 1'b1, 32'h80AABEEF);

        // Reset in the middle of a fill.
        addr  = 32'h304;
        width = W_W;
        re    = 1'b1;
        @(negedge clk);
        #1;
        check("fill_req_pre_rst", {31'h0, mem_req}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_drops_req", {31'h0, mem_req}, 32'h0);
        check("rst_drops_be", {28'h0, mem_be}, 32'h0);
        check("rst_idle_stall", {31'h0, stall}, 32'h1);
        re = 1'b0;
        #1;
        check("rst_idle_nostall", {31'h0, stall}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        load("lw_after_rst", W_W, 32'h304, 0, 2, 1'b1, 32'hCAFEF00D);
        load("lw_100_after_rst", W_W, 32'h100, 0, 2, 1'b1, 32'h80AABEEF);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
